adaptive_tlc_multiphase: RTL
============================

// Module: adaptive_tlc_multiphase
// PURPOSE
//  Parametrised successor of the 4-lane adaptive traffic light controller. Serves N_PHASES
//  approaches, one green at a time, with an internal phase timer. Green is demand-driven
//  (start sensors) and congestion-extended (congestion sensors), bounded by min/max green.
//  Phases are served round-robin with skip, followed by a yellow and all-red clearance.
//  Drives 2-bit light codes per phase directly; no separate driver is needed.
// PARAMETERS
//  N_PHASES     4   number of approaches/phases (2..16)
//  TW           8   timer width; every T_* parameter must be <= 2**TW-1
//  T_GREEN_MIN  10  minimum green, cycles
//  T_GREEN_EXT  10  extension added per congested expiry, cycles
//  T_GREEN_MAX  30  absolute green ceiling, cycles (>= T_GREEN_MIN)
//  T_YELLOW     3   yellow duration, cycles (>= 1)
//  T_ALLRED     1   all-red clearance, cycles (>= 1)
// PORTS
//  clk            in   1            system clock
//  rst            in   1            synchronous, active-low reset
//  start_sens     in   N_PHASES     S1 per phase: vehicle waiting
//  cong_sens      in   N_PHASES     S5 per phase: queue congested
//  lights         out  2*N_PHASES   phase i at [2i+1:2i]; 00 RED, 01 YELLOW, 10 GREEN
//  cur_phase      out  $clog2(N)    phase currently owning green/yellow/last served
//  current_state  out  2            00 ALLRED, 01 GREEN, 10 YELLOW
//  timer_q        out  TW           cycles elapsed in current state (saturating)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): current_state=ALLRED, timer_q=0, cur_phase=N_PHASES-1,
//    all lights RED, green target=T_GREEN_MIN. Reset mid-operation takes effect next edge.
//  - timer_q: cleared on every state change, else +1 per cycle, saturating at 2**TW-1.
//  - ALLRED: all RED. Once timer_q >= T_ALLRED-1, search (cur_phase+1) mod N upward for the
//    first phase with start_sens=1; if found: cur_phase<=it, GREEN, target=T_GREEN_MIN.
//    No demand anywhere: stay ALLRED (rest-in-red), re-evaluate every cycle.
//  - GREEN: lights[cur_phase]=GREEN, others RED. At timer_q == target-1:
//    * cong_sens[cur_phase]=1 and target<T_GREEN_MAX: target<=min(target+T_GREEN_EXT,
//      T_GREEN_MAX); stay GREEN.
//    * else if any other phase has start_sens=1: YELLOW.
//    * else hold GREEN (rest-on-green); leave for YELLOW on the first cycle another phase
//      demands. timer_q keeps counting/saturates; T_GREEN_MAX does not apply when no
//      other demand exists.
//    Sensor deassertion never shortens green below target.
//  - YELLOW: lights[cur_phase]=YELLOW; after T_YELLOW cycles -> ALLRED.
//  - Exactly one phase non-RED at any time; never GREEN->GREEN without YELLOW+ALLRED.
//  - Outputs are registered; lights change on the same edge as current_state.
//  - Same-cycle expiry + sensor change: sensors sampled on that edge decide.
// CONFIGURATION
//  EMERGENCY_PREEMPT_EN defined: adds ports emg_req (in,1) and emg_phase (in,$clog2(N)).
//   emg_req=1 in GREEN with cur_phase!=emg_phase: YELLOW next edge (min green waived).
//   In ALLRED at expiry: select emg_phase regardless of demand. GREEN on emg_phase holds
//   while emg_req=1 (no yellow). On release, normal rules resume with the current target.
//   Undefined: ports absent, no preemption logic.
// TESTING (N_PHASES=4, defaults)
//  1 rst=0 2 cycles, release, start_sens=0001 -> 1 cycle all RED, then lights=8'h02,
//    cur_phase=0, GREEN persists (rest-on-green) while no other demand.
//  2 phase 0 green, start_sens=1001 at timer_q=9, cong=0 -> YELLOW 3 cycles, ALLRED 1,
//    phase 3 GREEN (phases 1,2 skipped), lights=8'h80.
//  3 phase 0 green, cong_sens=0001 held, start_sens=0011 -> green exactly 30 cycles
//    (10+10+10, clamped), then YELLOW 3, ALLRED 1, phase 1 GREEN.
//  4 all sensors 0 after yellow -> stays ALLRED indefinitely; start_sens=0100 -> GREEN
//    phase 2 on next edge.
//  5 rst=0 asserted during YELLOW (timer_q=1) -> next edge all RED, timer_q=0,
//    cur_phase=3.
//  6 EMERGENCY_PREEMPT_EN: phase 1 green at timer_q=2, emg_req=1, emg_phase=2 ->
//    YELLOW next edge, then ALLRED 1, GREEN phase 2 held 50 cycles while emg_req=1.

Source files
------------

// File: rtl/adaptive_tlc_multiphase.sv
// adaptive_tlc_multiphase
//   Multi-phase adaptive traffic light controller. One approach at a time owns green;
//   green is demand-driven, extended under congestion up to T_GREEN_MAX, and followed by
//   yellow and an all-red clearance. Phases are served round-robin, skipping those with
//   no demand. With no demand anywhere the controller rests in all-red; with no competing
//   demand it rests on green.
//
// Optional feature: define EMERGENCY_PREEMPT_EN to add emergency preemption
//   (ports emg_req, emg_phase).
//
// Ports
//   clk            system clock
//   rst            synchronous active-low reset
//   start_sens     per-phase vehicle-waiting sensors
//   cong_sens      per-phase congestion sensors
//   emg_req        emergency request (EMERGENCY_PREEMPT_EN only)
//   emg_phase      phase to preempt to (EMERGENCY_PREEMPT_EN only)
//   lights         2-bit code per phase at [2i+1:2i]: 00 red, 01 yellow, 10 green
//   cur_phase      phase owning green/yellow, or last served
//   current_state  00 all-red, 01 green, 10 yellow
//   timer_q        cycles spent in the current state, saturating

module adaptive_tlc_multiphase #(
    parameter int unsigned N_PHASES    = 4,
    parameter int unsigned TW          = 8,
    parameter int unsigned T_GREEN_MIN = 10,
    parameter int unsigned T_GREEN_EXT = 10,
    parameter int unsigned T_GREEN_MAX = 30,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PHASES-1:0]         start_sens,
    input  logic [N_PHASES-1:0]         cong_sens,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                        emg_req,
    input  logic [$clog2(N_PHASES)-1:0] emg_phase,
`endif
    output logic [2*N_PHASES-1:0]       lights,
    output logic [$clog2(N_PHASES)-1:0] cur_phase,
    output logic [1:0]                  current_state,
    output logic [TW-1:0]               timer_q
);

    localparam int unsigned PW = $clog2(N_PHASES);

    localparam logic [TW-1:0] TGreenMin  = TW'(T_GREEN_MIN);
    localparam logic [TW-1:0] TGreenMax  = TW'(T_GREEN_MAX);
    localparam logic [TW:0]   TGreenExt  = (TW+1)'(T_GREEN_EXT);
    localparam logic [TW-1:0] TYellowM1  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] TAllRedM1  = TW'(T_ALLRED - 1);

    typedef enum logic [1:0] {
        StAllRed = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [TW-1:0]        target_q, target_d;
    logic [TW-1:0]        timer_d;
    logic [2*N_PHASES-1:0] lights_q, lights_d;

    logic                 found;
    logic [PW-1:0]        next_idx;
    logic [N_PHASES-1:0]  other_vec;
    logic                 other_demand;
    logic [TW-1:0]        target_m1;
    logic [TW:0]          ext_sum;
    logic [TW-1:0]        ext_target;

    // State register (outputs are registered alongside the state)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StAllRed;
            phase_q  <= PW'(N_PHASES - 1);
            target_q <= TGreenMin;
            timer_q  <= '0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            lights_q <= lights_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        target_d = target_q;

        // Round-robin search starting after the last served phase, wrapping to it last
        found    = 1'b0;
        next_idx = phase_q;
        for (int i = 1; i <= int'(N_PHASES); i++) begin
            if (!found && start_sens[(int'(phase_q) + i) % int'(N_PHASES)]) begin
                found    = 1'b1;
                next_idx = PW'((int'(phase_q) + i) % int'(N_PHASES));
            end
        end

        other_vec          = start_sens;
        other_vec[phase_q] = 1'b0;
        other_demand       = |other_vec;

        target_m1  = target_q - 1'b1;
        ext_sum    = {1'b0, target_q} + TGreenExt;
        ext_target = (ext_sum > {1'b0, TGreenMax}) ? TGreenMax : ext_sum[TW-1:0];

        unique case (state_q)
            StAllRed: begin
                if (timer_q >= TAllRedM1) begin
`ifdef EMERGENCY_PREEMPT_EN
                    if (emg_req) begin
                        state_d  = StGreen;
                        phase_d  = emg_phase;
                        target_d = TGreenMin;
                    end else
`endif
                    if (found) begin
                        state_d  = StGreen;
                        phase_d  = next_idx;
                        target_d = TGreenMin;
                    end
                end
            end
            StGreen: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (emg_req && (phase_q != emg_phase)) begin
                    state_d = StYellow;
                end else if (emg_req) begin
                    state_d = StGreen;
                end else
`endif
                // Extension only at the exact expiry point; past it we are resting on green
                if ((timer_q == target_m1) && cong_sens[phase_q] && (target_q < TGreenMax)) begin
                    target_d = ext_target;
                end else if ((timer_q >= target_m1) && other_demand) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (timer_q >= TYellowM1) begin
                    state_d = StAllRed;
                end
            end
            default: begin
                state_d = StAllRed;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Output logic: light codes derived from the next state so they update with it
    always_comb begin
        lights_d = '0;
        if (state_d == StGreen) begin
            lights_d[2*int'(phase_d) +: 2] = 2'b10;
        end else if (state_d == StYellow) begin
            lights_d[2*int'(phase_d) +: 2] = 2'b01;
        end
    end

    assign lights        = lights_q;
    assign cur_phase     = phase_q;
    assign current_state = state_q;

endmodule
